mod_counter_n: RTL and testbench



---
 rtl/mod_counter_n_pkg.sv | 6 +
 rtl/mod_counter_n_if.sv | 19 +
 rtl/mod_counter_n.sv | 55 +++++
 tb/tb_mod_counter_n.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mod_counter_n_pkg.sv
// counter_pkg: shared state and direction encodings for mod_counter_n
package counter_pkg;
  typedef enum logic {ST_COUNT = 1'b0, ST_HALT = 1'b1} state_e;
  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/mod_counter_n_if.sv
// mod_counter_n_if: control/status bundle of the programmable-modulo counter
interface mod_counter_n_if #(parameter int WIDTH = 8);
  logic             sclr;
  logic             load;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] limit;
  logic             up_dn;
  logic             one_shot;
  logic             ENP;
  logic             ENT;
  logic [WIDTH-1:0] Q;
  logic             RCO;
  logic             wrap;
  logic             done;
  modport master (output sclr, load, D, limit, up_dn, one_shot, ENP, ENT,
                  input  Q, RCO, wrap, done);
  modport slave  (input  sclr, load, D, limit, up_dn, one_shot, ENP, ENT,
                  output Q, RCO, wrap, done);
endinterface

// File: rtl/mod_counter_n.sv
// mod_counter_n: programmable-modulo up/down counter with load, one-shot halt and RCO cascade
module mod_counter_n
  import counter_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             clr,
  mod_counter_n_if.slave   bus
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             en, at_term;
  assign en      = bus.ENP & bus.ENT;
  // >= in up mode so a count loaded above limit still terminates
  assign at_term = (bus.up_dn == DIR_DOWN) ? (q_q == '0) : (q_q >= bus.limit);
  always_comb begin
    q_d     = q_q;
    state_d = state_q;
    wrap_d  = 1'b0;
    if (bus.sclr) begin
      q_d     = RESET_VAL;
      state_d = ST_COUNT;
    end else if (bus.load) begin
      q_d     = bus.D;
      state_d = ST_COUNT;
    end else if (en && state_q == ST_COUNT) begin
      if (!at_term) begin
        q_d = (bus.up_dn == DIR_UP) ? q_q + 1'b1 : q_q - 1'b1;
      end else begin
        wrap_d = 1'b1;
        if (bus.one_shot) state_d = ST_HALT;
        else q_d = (bus.up_dn == DIR_UP) ? '0 : bus.limit;
      end
    end
  end
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q_q     <= RESET_VAL;
      state_q <= ST_COUNT;
      wrap_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      state_q <= state_d;
      wrap_q  <= wrap_d;
    end
  end
  // RCO ignores ENP so cascaded stages see carry even when the low stage pauses
  assign bus.Q    = q_q;
  assign bus.RCO  = bus.ENT & at_term & (state_q == ST_COUNT);
  assign bus.wrap = wrap_q;
  assign bus.done = (state_q == ST_HALT);
endmodule

// File: tb/tb_mod_counter_n.sv
// tb_mod_counter_n: directed self-checking bench for mod_counter_n
module tb_mod_counter_n;
  logic clk = 1'b0;
  logic clr = 1'b0;
  int   n_chk = 0;
  int   n_bad = 0;
  always #5 clk = ~clk;
  mod_counter_n_if #(.WIDTH(8)) m ();
  mod_counter_n_if #(.WIDTH(4)) lo ();
  mod_counter_n_if #(.WIDTH(4)) hi ();
  assign hi.ENT = lo.RCO;
  mod_counter_n #(.WIDTH(8), .RESET_VAL(8'd0)) dut    (.clk(clk), .clr(clr), .bus(m));
  mod_counter_n #(.WIDTH(4), .RESET_VAL(4'd0)) dut_lo (.clk(clk), .clr(clr), .bus(lo));
  mod_counter_n #(.WIDTH(4), .RESET_VAL(4'd0)) dut_hi (.clk(clk), .clr(clr), .bus(hi));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int exp_dn[5];
    m.sclr = 0; m.load = 0; m.D = 0; m.limit = 8'd5; m.up_dn = 1;
    m.one_shot = 0; m.ENP = 0; m.ENT = 0;
    lo.sclr = 0; lo.load = 0; lo.D = 0; lo.limit = 4'd15; lo.up_dn = 1;
    lo.one_shot = 0; lo.ENP = 1; lo.ENT = 1;
    hi.sclr = 0; hi.load = 0; hi.D = 0; hi.limit = 4'd15; hi.up_dn = 1;
    hi.one_shot = 0; hi.ENP = 1;
    #3;
    chk("rst_q", m.Q, 0);
    chk("rst_wrap", m.wrap, 0);
    chk("rst_done", m.done, 0);
    chk("rst_rco_ent0", m.RCO, 0);
    @(negedge clk);
    clr = 1;
    m.ENP = 1; m.ENT = 1;
    for (int i = 1; i <= 14; i++) begin
      step();
      chk("up_q", m.Q, i % 6);
      chk("up_wrap", m.wrap, (i % 6 == 0) ? 1 : 0);
      chk("up_rco", m.RCO, (i % 6 == 5) ? 1 : 0);
    end
    m.up_dn = 0; m.limit = 8'd3; m.load = 1; m.D = 8'd3;
    step();
    chk("dn_load_q", m.Q, 3);
    chk("dn_load_wrap", m.wrap, 0);
    m.load = 0;
    exp_dn = '{2, 1, 0, 3, 2};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("dn_q", m.Q, exp_dn[i]);
      chk("dn_wrap", m.wrap, (i == 3) ? 1 : 0);
      chk("dn_rco", m.RCO, (exp_dn[i] == 0) ? 1 : 0);
    end
    m.sclr = 1;
    step();
    chk("sclr_q", m.Q, 0);
    m.sclr = 0; m.up_dn = 1; m.limit = 8'd4; m.one_shot = 1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("os_q", m.Q, i);
    end
    chk("os_rco_term", m.RCO, 1);
    chk("os_done_pre", m.done, 0);
    step();
    chk("os_halt_q", m.Q, 4);
    chk("os_halt_wrap", m.wrap, 1);
    chk("os_halt_done", m.done, 1);
    chk("os_halt_rco", m.RCO, 0);
    m.one_shot = 0;
    for (int i = 0; i < 10; i++) begin
      m.up_dn = i[0];
      m.limit = 8'(i);
      step();
    end
    chk("os_idle_q", m.Q, 4);
    chk("os_idle_done", m.done, 1);
    chk("os_idle_wrap", m.wrap, 0);
    m.up_dn = 1; m.limit = 8'd4; m.one_shot = 1; m.load = 1; m.D = 8'd1;
    step();
    chk("os_load_q", m.Q, 1);
    chk("os_load_done", m.done, 0);
    m.load = 0;
    step();
    chk("os_resume_q", m.Q, 2);
    m.one_shot = 0; m.limit = 8'd7; m.load = 1; m.D = 8'd7;
    step();
    chk("enp_load_q", m.Q, 7);
    m.load = 0; m.ENP = 0;
    step();
    chk("enp0_q", m.Q, 7);
    chk("enp0_wrap", m.wrap, 0);
    chk("enp0_rco", m.RCO, 1);
    m.ENT = 0;
    #1;
    chk("ent0_rco", m.RCO, 0);
    m.ENP = 1; m.ENT = 1; m.limit = 8'd10; m.load = 1; m.D = 8'd200;
    step();
    chk("over_q", m.Q, 200);
    chk("over_rco", m.RCO, 1);
    m.load = 0;
    step();
    chk("over_wrap_q", m.Q, 0);
    chk("over_wrap", m.wrap, 1);
    step();
    chk("over_next_q", m.Q, 1);
    m.sclr = 1; m.load = 1; m.D = 8'd9;
    step();
    chk("sclr_prio_q", m.Q, 0);
    m.sclr = 0; m.load = 0; m.limit = 8'd0;
    step();
    chk("lim0_q", m.Q, 0);
    chk("lim0_wrap", m.wrap, 1);
    m.up_dn = 0;
    step();
    chk("lim0_dn_q", m.Q, 0);
    chk("lim0_dn_wrap", m.wrap, 1);
    m.limit = 8'd3; m.load = 1; m.D = 8'd6;
    step();
    m.load = 0;
    for (int i = 5; i >= 0; i--) begin
      step();
      chk("dn_above_q", m.Q, i);
    end
    step();
    chk("dn_above_reload", m.Q, 3);
    chk("dn_above_wrap", m.wrap, 1);
    m.up_dn = 1; m.limit = 8'd2; m.one_shot = 1; m.sclr = 1;
    step();
    m.sclr = 0;
    step();
    step();
    step();
    chk("aclr_pre_q", m.Q, 2);
    chk("aclr_pre_done", m.done, 1);
    #3;
    clr = 0;
    #1;
    chk("aclr_q", m.Q, 0);
    chk("aclr_done", m.done, 0);
    chk("aclr_wrap", m.wrap, 0);
    #2;
    clr = 1;
    step();
    chk("aclr_resume_q", m.Q, 1);
    lo.sclr = 1; hi.sclr = 1;
    step();
    lo.sclr = 0; hi.sclr = 0;
    chk("casc_start", {hi.Q, lo.Q}, 0);
    for (int i = 1; i <= 256; i++) begin
      step();
      chk("casc_q", {hi.Q, lo.Q}, i % 256);
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
